// File: rtl/cacc_group_sched_if.sv
// CSB, dual-group and datapath-control signals of the CACC ping-pong scheduler.
// The slave modport is the scheduler; the master modport is its environment.
interface cacc_group_sched_if;
    logic [11:0] reg_offset;
    logic [31:0] reg_wr_data;
    logic        reg_wr_en;
    logic        reg_dual_sel;
    logic [31:0] reg_rd_data;
    logic        d0_op_en_trigger;
    logic        d1_op_en_trigger;
    logic        d0_wr_en;
    logic        d1_wr_en;
    logic        d0_op_en;
    logic        d1_op_en;
    logic        producer;
    logic        consumer;
    logic        dp_start;
    logic        dp_group;
    logic        dp_busy;
    logic        dp_done;
    logic [1:0]  done_intr;

    modport master (
        output reg_offset, reg_wr_data, reg_wr_en, reg_dual_sel,
        output d0_op_en_trigger, d1_op_en_trigger, dp_done,
        input  reg_rd_data, d0_wr_en, d1_wr_en, d0_op_en, d1_op_en,
        input  producer, consumer, dp_start, dp_group, dp_busy, done_intr
    );

    modport slave (
        input  reg_offset, reg_wr_data, reg_wr_en, reg_dual_sel,
        input  d0_op_en_trigger, d1_op_en_trigger, dp_done,
        output reg_rd_data, d0_wr_en, d1_wr_en, d0_op_en, d1_op_en,
        output producer, consumer, dp_start, dp_group, dp_busy, done_intr
    );
endinterface

// File: rtl/cacc_group_sched.sv
// Ping-pong scheduler for the CACC D0/D1 register groups: routes CSB writes to the
// producer group and runs/retires the consumer group on the accumulator datapath.
//
// state | meaning
// IDLE  | waiting for op_en of the consumer group
// START | one-cycle dp_start to the datapath
// RUN   | datapath busy, waiting for dp_done
// GAP   | enforced idle cycles after a retire
module cacc_group_sched #(
    parameter int IDLE_GAP = 2
) (
    input logic               nvdla_core_clk,
    input logic               nvdla_core_rst,
    cacc_group_sched_if.slave bus
);
    localparam int CW = (IDLE_GAP < 1) ? 1 : $clog2(IDLE_GAP + 1);
    localparam logic [CW-1:0] GAP_LOAD = (IDLE_GAP > 0) ? CW'(IDLE_GAP - 1) : '0;

    typedef enum logic [1:0] {S_IDLE, S_START, S_RUN, S_GAP} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [1:0]    op_en, op_set, op_clr;
    logic [1:0]    done_intr;
    logic          producer, consumer, dp_group;
    logic          retire, dp_start, dp_busy, ptr_wr;
    logic [1:0]    st0, st1;
    logic [31:0]   rd_data;
    logic          unused_wr_data;

    assign ptr_wr = bus.reg_wr_en & (bus.reg_offset == 12'h004);
    assign op_set = {bus.d1_op_en_trigger & bus.reg_wr_data[0],
                     bus.d0_op_en_trigger & bus.reg_wr_data[0]};
    assign op_clr = {retire & consumer, retire & ~consumer};
    // only bit 0 of the write data carries meaning for this block
    assign unused_wr_data = ^bus.reg_wr_data[31:1];

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        retire    = 1'b0;
        dp_start  = 1'b0;
        dp_busy   = 1'b0;
        case (state)
            S_IDLE: begin
                if (op_en[consumer]) state_nxt = S_START;
            end
            S_START: begin
                dp_start  = 1'b1;
                dp_busy   = 1'b1;
                state_nxt = S_RUN;
            end
            S_RUN: begin
                dp_busy = 1'b1;
                if (bus.dp_done) begin
                    retire = 1'b1;
                    if (IDLE_GAP == 0) begin
                        state_nxt = S_IDLE;
                    end else begin
                        state_nxt = S_GAP;
                        cnt_nxt   = GAP_LOAD;
                    end
                end
            end
            S_GAP: begin
                if (cnt == '0) state_nxt = S_IDLE;
                else           cnt_nxt   = cnt - 1'b1;
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge nvdla_core_clk or posedge nvdla_core_rst) begin
        if (nvdla_core_rst) begin
            state     <= S_IDLE;
            cnt       <= '0;
            op_en     <= 2'b00;
            producer  <= 1'b0;
            consumer  <= 1'b0;
            dp_group  <= 1'b0;
            done_intr <= 2'b00;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            op_en     <= (op_en & ~op_clr) | op_set;
            done_intr <= op_clr;
            if (ptr_wr) producer <= bus.reg_wr_data[0];
            if (retire) consumer <= ~consumer;
            if (state == S_IDLE && state_nxt == S_START) dp_group <= consumer;
        end
    end

    // status per group: 1 running, 2 enabled but not yet on the datapath, 0 idle
    always_comb begin
        st0 = 2'd0;
        st1 = 2'd0;
        if (dp_busy && !dp_group)     st0 = 2'd1;
        else if (op_en[0])            st0 = 2'd2;
        if (dp_busy && dp_group)      st1 = 2'd1;
        else if (op_en[1])            st1 = 2'd2;
        case (bus.reg_offset)
            12'h000: rd_data = {14'b0, st1, 14'b0, st0};
            12'h004: rd_data = {15'b0, consumer, 15'b0, producer};
            default: rd_data = 32'b0;
        endcase
    end

    assign bus.reg_rd_data = rd_data;
    assign bus.d0_wr_en    = bus.reg_wr_en & bus.reg_dual_sel & ~producer & ~op_en[0];
    assign bus.d1_wr_en    = bus.reg_wr_en & bus.reg_dual_sel &  producer & ~op_en[1];
    assign bus.d0_op_en    = op_en[0];
    assign bus.d1_op_en    = op_en[1];
    assign bus.producer    = producer;
    assign bus.consumer    = consumer;
    assign bus.dp_start    = dp_start;
    assign bus.dp_group    = dp_group;
    assign bus.dp_busy     = dp_busy;
    assign bus.done_intr   = done_intr;
endmodule
